// File: rtl/prefetch_pkg.sv
// Shared definitions for the instruction prefetch stage and the BUS_68020 request port.
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } pf_state_e;

    localparam logic [1:0] SIZE_LONG = 2'b00;

endpackage

// File: rtl/prefetch_queue_word_fifo.sv
// Circular 16-bit word buffer: push 0/1/2 words, pop 1, synchronous clear.
module word_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic [1:0]               push_n_i,
    input  logic [15:0]              wdata0_i,
    input  logic [15:0]              wdata1_i,
    input  logic                     pop_i,
    output logic [15:0]              head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] rptr_q, wptr_q, count_q;
    logic [AW-1:0] widx0, widx1;
    logic          pop_eff;

    assign widx0   = wptr_q[AW-1:0];
    assign widx1   = widx0 + AW'(1);
    assign pop_eff = pop_i && (count_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else if (clear_i) begin
            rptr_q  <= wptr_q;
            count_q <= '0;
        end else begin
            if (push_n_i != 2'd0) mem_q[widx0] <= wdata0_i;
            if (push_n_i == 2'd2) mem_q[widx1] <= wdata1_i;
            wptr_q  <= wptr_q + PW'(push_n_i);
            rptr_q  <= rptr_q + PW'(pop_eff);
            count_q <= count_q + PW'(push_n_i) - PW'(pop_eff);
        end
    end

    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Sequential longword prefetch into a word queue, with branch redirect and in-flight discard.
module prefetch_queue #(
    parameter int unsigned DEPTH_WORDS = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        o_BReq,
    output logic [31:0] o_AddrReq,
    output logic [1:0]  o_SizeReq,
    input  logic        i_BReqComplete,
    input  logic [31:0] i_Data,
    input  logic        i_Flush,
    input  logic [31:0] i_FlushPC,
    output logic        o_Valid,
    output logic [15:0] o_Word,
    output logic [31:0] o_WordPC,
    input  logic        i_Consume
);
    import prefetch_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH_WORDS) + 1;

    pf_state_e   state_q, state_d;
    logic        breq_q, breq_d;
    logic [31:0] addr_req_q, addr_req_d;
    logic [31:0] fetch_q, fetch_d;
    logic        skip_q, skip_d;
    logic [31:0] head_pc_q, head_pc_d;

    logic [CW-1:0] fifo_count, free_slots, need_slots;
    logic [1:0]    push_n;
    logic [15:0]   word0;
    logic          pop;
    logic          unused_flush_bit0;

    assign unused_flush_bit0 = i_FlushPC[0];

    assign free_slots = CW'(DEPTH_WORDS) - fifo_count;
    assign need_slots = skip_q ? CW'(1) : CW'(2);
    assign pop        = i_Consume && o_Valid && !i_Flush;
    assign push_n     = (state_q == WAIT && i_BReqComplete && !i_Flush)
                        ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    assign word0      = skip_q ? i_Data[15:0] : i_Data[31:16];

    word_fifo #(
        .DEPTH(DEPTH_WORDS)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clear_i (i_Flush),
        .push_n_i(push_n),
        .wdata0_i(word0),
        .wdata1_i(i_Data[15:0]),
        .pop_i   (pop),
        .head_o  (o_Word),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        breq_d     = 1'b0;
        addr_req_d = addr_req_q;
        fetch_d    = fetch_q;
        skip_d     = skip_q;
        head_pc_d  = head_pc_q;

        if (pop) head_pc_d = head_pc_q + 32'd2;

        case (state_q)
            IDLE: begin
                if (!i_Flush && free_slots >= need_slots) begin
                    state_d    = REQ;
                    breq_d     = 1'b1;
                    addr_req_d = fetch_q;
                end
            end
            REQ:  state_d = i_Flush ? DISCARD : WAIT;
            WAIT: begin
                if (i_BReqComplete) begin
                    state_d = IDLE;
                    fetch_d = fetch_q + 32'd4;
                    skip_d  = 1'b0;
                end else if (i_Flush) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: if (i_BReqComplete) state_d = IDLE;
        endcase

        // Redirect overrides any fetch-address advance from a same-cycle completion.
        if (i_Flush) begin
            head_pc_d = {i_FlushPC[31:1], 1'b0};
            fetch_d   = {i_FlushPC[31:2], 2'b00};
            skip_d    = i_FlushPC[1];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            breq_q     <= 1'b0;
            addr_req_q <= {RESET_PC[31:2], 2'b00};
            fetch_q    <= {RESET_PC[31:2], 2'b00};
            skip_q     <= RESET_PC[1];
            head_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            breq_q     <= breq_d;
            addr_req_q <= addr_req_d;
            fetch_q    <= fetch_d;
            skip_q     <= skip_d;
            head_pc_q  <= head_pc_d;
        end
    end

    assign o_BReq    = breq_q;
    assign o_AddrReq = addr_req_q;
    assign o_SizeReq = SIZE_LONG;
    assign o_Valid   = (fifo_count != '0);
    assign o_WordPC  = head_pc_q;

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch stage directly upstream of BUS_68020; drives its internal request port (r_BReq / r_AddrReq / r_SizeReq) and consumes r_BReqComplete / r_Data.
- Fetches aligned longwords sequentially, splits each into two big-endian 16-bit words and buffers them in a circular word queue for the decoder.
- Supports flush/redirect on branch, including discard of an in-flight fetch.

Parameters:
- DEPTH_WORDS, 8, queue capacity in 16-bit words; power of 2, >= 4
- RESET_PC, 32'h0000_0000, fetch address after reset; must be word aligned

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- o_BReq  out  1  one-cycle request strobe to BUS_68020 (r_BReq)
- o_AddrReq  out  32  longword-aligned byte address (r_AddrReq); bits [1:0] always 0
- o_SizeReq  out  2  transfer size (r_SizeReq); always 2'b00 (long)
- i_BReqComplete  in  1  one-cycle pulse, i_Data valid in the same cycle
- i_Data  in  32  returned longword (r_Data)
- i_Flush  in  1  one-cycle redirect strobe
- i_FlushPC  in  32  new fetch PC; bit 0 ignored
- o_Valid  out  1  head word available
- o_Word  out  16  head word
- o_WordPC  out  32  byte address of head word
- i_Consume  in  1  pop head word; ignored when o_Valid = 0

Behaviour:
- Reset values: o_BReq = 0, o_AddrReq = {RESET_PC[31:2], 2'b00}, o_SizeReq = 2'b00, o_Valid = 0, o_Word = 0, o_WordPC = RESET_PC, count = 0, state = IDLE, skip_upper = RESET_PC[1].
- Word storage: circular buffer of DEPTH_WORDS x 16; read pointer, write pointer and count of width $clog2(DEPTH_WORDS)+1; pointers wrap modulo DEPTH_WORDS.
- Longword split: i_Data[31:16] is written at the lower address, i_Data[15:0] at address + 2. If skip_upper = 1, only [15:0] is written, then skip_upper clears.
- FSM states:
  - IDLE: if free slots >= 2 (and the current long is not a skipped half), go to REQ.
  - REQ: o_BReq = 1 for exactly 1 cycle; go to WAIT. o_AddrReq and o_SizeReq stay stable from REQ until completion.
  - WAIT: on i_BReqComplete, write the words, add 4 to the fetch address, go to IDLE.
  - DISCARD: on i_BReqComplete, drop the data and go to IDLE with the new fetch address.
- Only one request is outstanding at a time. The free-space check is made at IDLE, so a completion never overflows the queue.
- Latency:
  - First o_BReq in the 2nd CLK edge after RESET falls.
  - Completion in cycle N gives o_Valid = 1 in cycle N+1.
  - Steady-state IDLE->REQ costs 1 cycle.
- Consume: on i_Consume with o_Valid = 1, rptr++, count--, o_WordPC += 2. o_Word and o_WordPC are combinational from the head entry / head PC register.
- Simultaneous consume + completion in the same cycle: both take effect; count changes by +2-1 (or +1-1 when skipping).
- Flush has priority over consume and completion in the same cycle:
  - Queue empties (count = 0, pointers equalised).
  - o_WordPC = {i_FlushPC[31:1], 0}; fetch address = {i_FlushPC[31:2], 00}; skip_upper = i_FlushPC[1].
  - State WAIT -> DISCARD; state REQ -> DISCARD (the strobe was already issued this cycle).
  - Completion in the same cycle as the flush is discarded.
  - Flush while in DISCARD updates the target only.
- Fetch address wraps 32'hFFFF_FFFC -> 0 silently.
- Full queue: no request is issued; i_Consume frees slots and fetching resumes at the next IDLE evaluation.
- RESET asserted mid-fetch clears everything immediately. A later stray i_BReqComplete while in IDLE is ignored.

Decomposition:
- Shared package prefetch_pkg: FSM state encoding (IDLE, REQ, WAIT, DISCARD) and SIZE_LONG = 2'b00, shared with BUS_68020 size decoding.
- One natural sub-module: word_fifo (dual-write-capable circular buffer: push 1 or 2 words, pop 1, count output).

Test Plan:
- Reset release, RESET_PC = 0, bus returns 32'h4E71_4E75 -> o_BReq once with o_AddrReq = 0, then o_Word = 16'h4E71 at PC 0 and 16'h4E75 at PC 2.
- No consumption, DEPTH_WORDS = 8 -> exactly 4 requests (addresses 0, 4, 8, C), then o_BReq stays 0; one consume doesn't re-fetch, a second consume fetches 32'h10.
- Flush to 32'h0000_1002 while idle -> request at 32'h1000; data 32'hAAAA_BBBB yields only 16'hBBBB with o_WordPC = 32'h1002.
- Flush to 32'h200 during WAIT; old completion returns 32'hDEAD_BEEF -> data dropped, next request at 32'h200, first word from 32'h200.
- Consume and completion in the same cycle with count = 1 -> count = 2, order preserved.
- RESET pulse during WAIT -> o_Valid = 0, o_BReq = 0 immediately; restart at RESET_PC.
